forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 197 +++++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit
//
// Operand forwarding selection and load-use hazard control for a five-stage
// in-order pipeline.
//
// Forwarding: each EX-stage source picks its operand from the register file
// (00), the EX/MEM result (10) or the MEM/WB result (01). EX/MEM is the
// younger producer, so it has priority. Register 0 is never forwarded.
//
// Load-use hazard: when the EX-stage instruction is a load whose destination
// is read by the ID-stage instruction, the front end is frozen and a bubble is
// inserted for LOAD_LAT cycles. A two-state FSM with a 4-bit down-counter
// covers the cycles after the first one. A branch flush overrides everything.
//
// Ports
//   clk, arst          clock, asynchronous active-high reset
//   reg_write_ex_mem   EX/MEM writes the register file
//   rd_ex_mem          EX/MEM destination
//   reg_write_mem_wb   MEM/WB writes the register file
//   rd_mem_wb          MEM/WB destination
//   rs_id_ex           EX-stage sources, source i at [i*ADDR_W +: ADDR_W]
//   rs_if_id           ID-stage sources, same packing
//   rs_used_if_id      bit i set: ID source i is actually read
//   mem_read_id_ex     EX-stage instruction is a load
//   rd_id_ex           EX-stage destination
//   flush              synchronous pipeline flush
//   stat_clr           synchronous clear of stall_count
//   forward_sel        per-source operand mux select at [2i +: 2]
//   pc_write_en        PC update enable
//   if_id_write_en     IF/ID register enable
//   id_ex_bubble       force a NOP into ID/EX
//   stall_count        saturating count of stalled cycles
// ---------------------------------------------------------------------------
module forward_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      reg_write_ex_mem,
    input  logic [ADDR_W-1:0]         rd_ex_mem,
    input  logic                      reg_write_mem_wb,
    input  logic [ADDR_W-1:0]         rd_mem_wb,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_id_ex,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_if_id,
    input  logic [NUM_SRC-1:0]        rs_used_if_id,
    input  logic                      mem_read_id_ex,
    input  logic [ADDR_W-1:0]         rd_id_ex,
    input  logic                      flush,
    input  logic                      stat_clr,
    output logic [NUM_SRC*2-1:0]      forward_sel,
    output logic                      pc_write_en,
    output logic                      if_id_write_en,
    output logic                      id_ex_bubble,
    output logic [CNT_W-1:0]          stall_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_REG  = {ADDR_W{1'b0}};
    // The first stall cycle is spent in IDLE, so the counter covers the rest.
    localparam logic [3:0]        BUB_LOAD  = 4'(LOAD_LAT - 1);
    localparam logic              MULTI_BUB = (LOAD_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        bub_cnt_r;
    logic [3:0]        bub_cnt_nxt_s;
    logic              hazard_now_s;
    logic              stall_act_s;
    logic [CNT_W-1:0]  stall_count_r;

    // Forwarding select for one source; EX/MEM outranks MEM/WB, r0 never forwards.
    function automatic logic [1:0] fwd_sel_f(
        input logic [ADDR_W-1:0] src,
        input logic              wr_ex_mem,
        input logic [ADDR_W-1:0] dst_ex_mem,
        input logic              wr_mem_wb,
        input logic [ADDR_W-1:0] dst_mem_wb
    );
        logic [1:0] sel;
        if (wr_ex_mem && (dst_ex_mem != ZERO_REG) && (dst_ex_mem == src)) begin
            sel = 2'b10;
        end else if (wr_mem_wb && (dst_mem_wb != ZERO_REG) && (dst_mem_wb == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Per-source forwarding mux selects, evaluated independently.
    always_comb begin
        forward_sel = {(NUM_SRC*2){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            forward_sel[2*i +: 2] = fwd_sel_f(rs_id_ex[i*ADDR_W +: ADDR_W],
                                              reg_write_ex_mem, rd_ex_mem,
                                              reg_write_mem_wb, rd_mem_wb);
        end
    end

    // Load-use detection: only sources the ID instruction really reads count.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit = hit | (rs_used_if_id[i] & (rs_if_id[i*ADDR_W +: ADDR_W] == rd_id_ex));
        end
        hazard_now_s = mem_read_id_ex & (rd_id_ex != ZERO_REG) & hit;
    end

    // FSM next state and bubble counter; flush overrides every state.
    always_comb begin
        state_nxt_s   = state_r;
        bub_cnt_nxt_s = bub_cnt_r;
        if (flush) begin
            state_nxt_s   = IDLE;
            bub_cnt_nxt_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hazard_now_s && MULTI_BUB) begin
                        state_nxt_s   = STALL;
                        bub_cnt_nxt_s = BUB_LOAD;
                    end else begin
                        state_nxt_s   = IDLE;
                        bub_cnt_nxt_s = 4'd0;
                    end
                end
                STALL: begin
                    // A fresh hazard here does not reload the counter.
                    // "<= 1" also pulls an unexpected zero count back to IDLE.
                    if (bub_cnt_r <= 4'd1) begin
                        state_nxt_s   = IDLE;
                        bub_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s   = STALL;
                        bub_cnt_nxt_s = bub_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    bub_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // Stall decision; reset is included so the front end runs during arst
    // even while a hazard is present on the inputs.
    always_comb begin
        if (arst || flush) begin
            stall_act_s = 1'b0;
        end else begin
            stall_act_s = (hazard_now_s && (state_r == IDLE)) || (state_r == STALL);
        end
    end

    // FSM state and bubble counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r   <= IDLE;
            bub_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            bub_cnt_r <= bub_cnt_nxt_s;
        end
    end

    // Saturating stall statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_count_r <= CNT_ZERO;
        end else if (stat_clr) begin
            stall_count_r <= CNT_ZERO;
        end else if (stall_act_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign pc_write_en    = ~stall_act_s;
    assign if_id_write_en = ~stall_act_s;
    assign id_ex_bubble   = stall_act_s | flush;
    assign stall_count    = stall_count_r;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit. Three instances:
//   A: LOAD_LAT=3, CNT_W=16   C: LOAD_LAT=1, CNT_W=16 (same inputs as A)
//   B: LOAD_LAT=4, CNT_W=2    (own hazard/flush/clear inputs)
// Forwarding inputs are shared by all instances.
module tb_forward_hazard_unit;

    logic        clk;
    logic        arst;
    logic        reg_write_ex_mem;
    logic [4:0]  rd_ex_mem;
    logic        reg_write_mem_wb;
    logic [4:0]  rd_mem_wb;
    logic [9:0]  rs_id_ex;

    logic [9:0]  a_rs_if_id;
    logic [1:0]  a_rs_used;
    logic        a_mem_read;
    logic [4:0]  a_rd_id_ex;
    logic        a_flush;
    logic        a_stat_clr;

    logic [9:0]  b_rs_if_id;
    logic [1:0]  b_rs_used;
    logic        b_mem_read;
    logic [4:0]  b_rd_id_ex;
    logic        b_flush;
    logic        b_stat_clr;

    logic [3:0]  fs_a, fs_b, fs_c;
    logic        pc_a, pc_b, pc_c;
    logic        ifid_a, ifid_b, ifid_c;
    logic        bub_a, bub_b, bub_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    forward_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) dut_a (
        .clk(clk), .arst(arst),
        .reg_write_ex_mem(reg_write_ex_mem), .rd_ex_mem(rd_ex_mem),
        .reg_write_mem_wb(reg_write_mem_wb), .rd_mem_wb(rd_mem_wb),
        .rs_id_ex(rs_id_ex), .rs_if_id(a_rs_if_id), .rs_used_if_id(a_rs_used),
        .mem_read_id_ex(a_mem_read), .rd_id_ex(a_rd_id_ex),
        .flush(a_flush), .stat_clr(a_stat_clr),
        .forward_sel(fs_a), .pc_write_en(pc_a), .if_id_write_en(ifid_a),
        .id_ex_bubble(bub_a), .stall_count(cnt_a)
    );

    forward_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_c (
        .clk(clk), .arst(arst),
        .reg_write_ex_mem(reg_write_ex_mem), .rd_ex_mem(rd_ex_mem),
        .reg_write_mem_wb(reg_write_mem_wb), .rd_mem_wb(rd_mem_wb),
        .rs_id_ex(rs_id_ex), .rs_if_id(a_rs_if_id), .rs_used_if_id(a_rs_used),
        .mem_read_id_ex(a_mem_read), .rd_id_ex(a_rd_id_ex),
        .flush(a_flush), .stat_clr(a_stat_clr),
        .forward_sel(fs_c), .pc_write_en(pc_c), .if_id_write_en(ifid_c),
        .id_ex_bubble(bub_c), .stall_count(cnt_c)
    );

    forward_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(4), .CNT_W(2)) dut_b (
        .clk(clk), .arst(arst),
        .reg_write_ex_mem(reg_write_ex_mem), .rd_ex_mem(rd_ex_mem),
        .reg_write_mem_wb(reg_write_mem_wb), .rd_mem_wb(rd_mem_wb),
        .rs_id_ex(rs_id_ex), .rs_if_id(b_rs_if_id), .rs_used_if_id(b_rs_used),
        .mem_read_id_ex(b_mem_read), .rd_id_ex(b_rd_id_ex),
        .flush(b_flush), .stat_clr(b_stat_clr),
        .forward_sel(fs_b), .pc_write_en(pc_b), .if_id_write_en(ifid_b),
        .id_ex_bubble(bub_b), .stall_count(cnt_b)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        arst = 1'b1;
        reg_write_ex_mem = 1'b0; rd_ex_mem = 5'd0;
        reg_write_mem_wb = 1'b0; rd_mem_wb = 5'd0;
        rs_id_ex = 10'd0;
        a_rs_if_id = 10'd0; a_rs_used = 2'b00; a_mem_read = 1'b0;
        a_rd_id_ex = 5'd0;  a_flush = 1'b0;    a_stat_clr = 1'b0;
        b_rs_if_id = 10'd0; b_rs_used = 2'b00; b_mem_read = 1'b0;
        b_rd_id_ex = 5'd0;  b_flush = 1'b0;    b_stat_clr = 1'b0;

        // ---- reset state ----
        #3;
        chk("rst_pc",     {31'd0, pc_a},   32'd1);
        chk("rst_ifid",   {31'd0, ifid_a}, 32'd1);
        chk("rst_bubble", {31'd0, bub_a},  32'd0);
        chk("rst_cnt",    {16'd0, cnt_a},  32'd0);
        chk("rst_fs",     {28'd0, fs_a},   32'd0);
        a_flush = 1'b1;
        #1;
        chk("rst_flush_bubble", {31'd0, bub_a}, 32'd1);
        a_flush = 1'b0;
        // hazard pattern while in reset must not stall
        a_mem_read = 1'b1; a_rd_id_ex = 5'd7; a_rs_if_id = {5'd7, 5'd2}; a_rs_used = 2'b11;
        #1;
        chk("rst_hazard_pc", {31'd0, pc_a}, 32'd1);
        // forwarding follows inputs while in reset
        reg_write_ex_mem = 1'b1; rd_ex_mem = 5'd9; rs_id_ex = {5'd0, 5'd9};
        #1;
        chk("rst_fs_live", {28'd0, fs_a}, 32'h2);
        a_mem_read = 1'b0; reg_write_ex_mem = 1'b0; rd_ex_mem = 5'd0; rs_id_ex = 10'd0;
        @(negedge clk);
        arst = 1'b0;
        tick();

        // ---- forwarding ----
        reg_write_ex_mem = 1'b1; rd_ex_mem = 5'd3;
        reg_write_mem_wb = 1'b1; rd_mem_wb = 5'd3;
        rs_id_ex = {5'd9, 5'd3};
        #1;
        chk("fwd_exmem_prio", {28'd0, fs_a}, 32'h2);
        rd_ex_mem = 5'd0; rd_mem_wb = 5'd5; rs_id_ex = {5'd5, 5'd0};
        #1;
        chk("fwd_zero_reg", {28'd0, fs_a}, 32'h4);
        reg_write_ex_mem = 1'b0; rd_ex_mem = 5'd4; rd_mem_wb = 5'd4; rs_id_ex = {5'd4, 5'd4};
        #1;
        chk("fwd_memwb_both", {28'd0, fs_a}, 32'h5);
        reg_write_mem_wb = 1'b0;
        #1;
        chk("fwd_no_write", {28'd0, fs_a}, 32'h0);
        reg_write_ex_mem = 1'b1; rd_ex_mem = 5'd6; rs_id_ex = {5'd6, 5'd2};
        #1;
        chk("fwd_exmem_src1", {28'd0, fs_a}, 32'h8);
        reg_write_ex_mem = 1'b0;

        // ---- load-use, LOAD_LAT=3 (A) and LOAD_LAT=1 (C) ----
        tick();
        a_mem_read = 1'b1; a_rd_id_ex = 5'd7; a_rs_if_id = {5'd7, 5'd2}; a_rs_used = 2'b11;
        #1;
        chk("lu_c0_pc",     {31'd0, pc_a},   32'd0);
        chk("lu_c0_ifid",   {31'd0, ifid_a}, 32'd0);
        chk("lu_c0_bubble", {31'd0, bub_a},  32'd1);
        chk("lu_c0_pc_c",   {31'd0, pc_c},   32'd0);
        tick();
        a_mem_read = 1'b0;
        #1;
        chk("lu_c1_pc",   {31'd0, pc_a}, 32'd0);
        chk("lu_c1_pc_c", {31'd0, pc_c}, 32'd1);
        tick();
        chk("lu_c2_pc",   {31'd0, pc_a},  32'd0);
        chk("lu_c2_cnt",  {16'd0, cnt_a}, 32'd2);
        tick();
        chk("lu_done_pc",    {31'd0, pc_a},  32'd1);
        chk("lu_done_cnt",   {16'd0, cnt_a}, 32'd3);
        chk("lu_done_cnt_c", {16'd0, cnt_c}, 32'd1);

        // ---- unused source / zero destination: no stall ----
        a_mem_read = 1'b1; a_rs_used = 2'b01;
        #1;
        chk("unused_pc", {31'd0, pc_a}, 32'd1);
        a_rd_id_ex = 5'd0; a_rs_if_id = {5'd0, 5'd0}; a_rs_used = 2'b11;
        #1;
        chk("zero_rd_pc", {31'd0, pc_a}, 32'd1);
        tick();
        chk("nostall_cnt", {16'd0, cnt_a}, 32'd3);

        // ---- stat_clr wins over increment ----
        a_rd_id_ex = 5'd7; a_rs_if_id = {5'd7, 5'd2}; a_stat_clr = 1'b1;
        #1;
        chk("clr_pc", {31'd0, pc_a}, 32'd0);
        tick();
        a_mem_read = 1'b0; a_stat_clr = 1'b0;
        #1;
        chk("clr_cnt",   {16'd0, cnt_a}, 32'd0);
        chk("clr_cnt_c", {16'd0, cnt_c}, 32'd0);
        tick();
        tick();
        chk("clr_after_pc",  {31'd0, pc_a},  32'd1);
        chk("clr_after_cnt", {16'd0, cnt_a}, 32'd2);

        // ---- flush mid-stall, LOAD_LAT=4 (B) ----
        b_mem_read = 1'b1; b_rd_id_ex = 5'd7; b_rs_if_id = {5'd7, 5'd1}; b_rs_used = 2'b10;
        #1;
        chk("fl_c0_pc", {31'd0, pc_b}, 32'd0);
        tick();
        b_mem_read = 1'b0; b_flush = 1'b1;
        #1;
        chk("fl_c1_pc",     {31'd0, pc_b},  32'd1);
        chk("fl_c1_bubble", {31'd0, bub_b}, 32'd1);
        tick();
        b_flush = 1'b0;
        #1;
        chk("fl_idle_pc", {31'd0, pc_b},  32'd1);
        chk("fl_cnt",     {30'd0, cnt_b}, 32'd1);
        // hazard together with flush in IDLE: no stall, no FSM entry
        b_mem_read = 1'b1; b_flush = 1'b1;
        #1;
        chk("fl_haz_pc", {31'd0, pc_b}, 32'd1);
        tick();
        b_mem_read = 1'b0; b_flush = 1'b0;
        #1;
        chk("fl_haz_next_pc", {31'd0, pc_b},  32'd1);
        chk("fl_haz_cnt",     {30'd0, cnt_b}, 32'd1);

        // ---- saturation, CNT_W=2: four more stall cycles ----
        b_mem_read = 1'b1;
        tick();
        b_mem_read = 1'b0;
        tick();
        chk("sat_mid_cnt", {30'd0, cnt_b}, 32'd3);
        chk("sat_mid_pc",  {31'd0, pc_b},  32'd0);
        tick();
        tick();
        chk("sat_cnt",     {30'd0, cnt_b}, 32'd3);
        chk("sat_done_pc", {31'd0, pc_b},  32'd1);

        // ---- asynchronous reset mid-stall ----
        b_mem_read = 1'b1;
        tick();
        b_mem_read = 1'b0;
        #1;
        chk("ar_stall_pc", {31'd0, pc_b}, 32'd0);
        arst = 1'b1;
        #1;
        chk("ar_pc",    {31'd0, pc_b},   32'd1);
        chk("ar_ifid",  {31'd0, ifid_b}, 32'd1);
        chk("ar_cnt_b", {30'd0, cnt_b},  32'd0);
        chk("ar_cnt_a", {16'd0, cnt_a},  32'd0);
        tick();
        arst = 1'b0;
        tick();
        chk("ar_after_pc", {31'd0, pc_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
